// File: rtl/mips_pkg.sv
// Shared widths, control-bus bit positions, bubble constants and the ID/EX payload type.
package mips_pkg;

    localparam int unsigned NB_DATA    = 32;
    localparam int unsigned NB_REG     = 5;
    localparam int unsigned NB_CTRL_EX = 6;
    localparam int unsigned NB_CTRL_M  = 9;
    localparam int unsigned NB_CTRL_WB = 2;
    localparam int unsigned NB_CNT     = 16;

    localparam int unsigned MEM_READ_IDX    = 1;
    localparam int unsigned WB_REGWRITE_IDX = 1;

    localparam logic [NB_CTRL_WB-1:0] BUBBLE_WB  = '0;
    localparam logic [NB_CTRL_M-1:0]  BUBBLE_MEM = '0;
    localparam logic [NB_CTRL_EX-1:0] BUBBLE_EXC = '0;

    // Everything carried from ID into EX.
    typedef struct packed {
        logic [NB_CTRL_WB-1:0] ctrl_wb;
        logic [NB_CTRL_M-1:0]  ctrl_mem;
        logic [NB_CTRL_EX-1:0] ctrl_exc;
        logic                  jal;
        logic                  jalr;
        logic                  jr;
        logic                  shift;
        logic                  shamt_sel;
        logic [NB_DATA-1:0]    pc_plus4;
        logic [NB_DATA-1:0]    rs_data;
        logic [NB_DATA-1:0]    rt_data;
        logic [NB_DATA-1:0]    imm_ext;
        logic [NB_REG-1:0]     rs;
        logic [NB_REG-1:0]     rt;
        logic [NB_REG-1:0]     rd;
        logic [NB_REG-1:0]     shamt;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
    import mips_pkg::*;
(
    input  logic              ex_mem_read,
    input  logic [NB_REG-1:0] ex_rt,
    input  logic [NB_REG-1:0] id_rs,
    input  logic [NB_REG-1:0] id_rt,
    output logic              hazard
);

    // $zero never carries a real dependency.
    assign hazard = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush bubbles and optional load-use stall detection.
// Build option: define ID_EX_HAZARD_DETECT_EN to enable load-use stalls and the bubble counter.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
    input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
    input  logic                  i_jal,
    input  logic                  i_jalr,
    input  logic                  i_jr,
    input  logic                  i_shift,
    input  logic                  i_shamt_sel,
    input  logic [NB_DATA-1:0]    i_pc_plus4,
    input  logic [NB_DATA-1:0]    i_rs_data,
    input  logic [NB_DATA-1:0]    i_rt_data,
    input  logic [NB_DATA-1:0]    i_imm_ext,
    input  logic [NB_REG-1:0]     i_rs,
    input  logic [NB_REG-1:0]     i_rt,
    input  logic [NB_REG-1:0]     i_rd,
    input  logic [NB_REG-1:0]     i_shamt,
    output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
    output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
    output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
    output logic                  o_jal,
    output logic                  o_jalr,
    output logic                  o_jr,
    output logic                  o_shift,
    output logic                  o_shamt_sel,
    output logic [NB_DATA-1:0]    o_pc_plus4,
    output logic [NB_DATA-1:0]    o_rs_data,
    output logic [NB_DATA-1:0]    o_rt_data,
    output logic [NB_DATA-1:0]    o_imm_ext,
    output logic [NB_REG-1:0]     o_rs,
    output logic [NB_REG-1:0]     o_rt,
    output logic [NB_REG-1:0]     o_rd,
    output logic [NB_REG-1:0]     o_shamt,
    output logic                  o_stall,
    output logic [NB_CNT-1:0]     o_stall_count
);

    id_ex_t pipe_d, pipe_q;
    id_ex_t pipe_in;
    logic   stall_c;
    logic   bubble_c;

    assign pipe_in = '{
        ctrl_wb:   i_ctrl_wb_bus,
        ctrl_mem:  i_ctrl_mem_bus,
        ctrl_exc:  i_ctrl_exc_bus,
        jal:       i_jal,
        jalr:      i_jalr,
        jr:        i_jr,
        shift:     i_shift,
        shamt_sel: i_shamt_sel,
        pc_plus4:  i_pc_plus4,
        rs_data:   i_rs_data,
        rt_data:   i_rt_data,
        imm_ext:   i_imm_ext,
        rs:        i_rs,
        rt:        i_rt,
        rd:        i_rd,
        shamt:     i_shamt
    };

`ifdef ID_EX_HAZARD_DETECT_EN
    logic [NB_CNT-1:0] stall_count_d, stall_count_q;

    load_use_detect u_load_use_detect (
        .ex_mem_read (pipe_q.ctrl_mem[MEM_READ_IDX]),
        .ex_rt       (pipe_q.rt),
        .id_rs       (i_rs),
        .id_rt       (i_rt),
        .hazard      (stall_c)
    );

    // Counts stall bubbles only; a coincident flush owns the bubble.
    always_comb begin
        stall_count_d = stall_count_q;
        if (i_enable && stall_c && !i_flush && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign o_stall_count = stall_count_q;
`else
    assign stall_c       = 1'b0;
    assign o_stall_count = '0;
`endif

    assign bubble_c = i_flush | stall_c;

    // Bubble clears control and flags only; datapath fields load as usual.
    always_comb begin
        pipe_d = pipe_q;
        if (i_enable) begin
            pipe_d = pipe_in;
            if (bubble_c) begin
                pipe_d.ctrl_wb   = BUBBLE_WB;
                pipe_d.ctrl_mem  = BUBBLE_MEM;
                pipe_d.ctrl_exc  = BUBBLE_EXC;
                pipe_d.jal       = 1'b0;
                pipe_d.jalr      = 1'b0;
                pipe_d.jr        = 1'b0;
                pipe_d.shift     = 1'b0;
                pipe_d.shamt_sel = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign o_ctrl_wb_bus  = pipe_q.ctrl_wb;
    assign o_ctrl_mem_bus = pipe_q.ctrl_mem;
    assign o_ctrl_exc_bus = pipe_q.ctrl_exc;
    assign o_jal          = pipe_q.jal;
    assign o_jalr         = pipe_q.jalr;
    assign o_jr           = pipe_q.jr;
    assign o_shift        = pipe_q.shift;
    assign o_shamt_sel    = pipe_q.shamt_sel;
    assign o_pc_plus4     = pipe_q.pc_plus4;
    assign o_rs_data      = pipe_q.rs_data;
    assign o_rt_data      = pipe_q.rt_data;
    assign o_imm_ext      = pipe_q.imm_ext;
    assign o_rs           = pipe_q.rs;
    assign o_rt           = pipe_q.rt;
    assign o_rd           = pipe_q.rd;
    assign o_shamt        = pipe_q.shamt;
    assign o_stall        = stall_c;

endmodule
